// File: rtl/eeprom_boot_sequencer_if.sv
// Bootstrap bus shared between the boot sequencer, the parallel EEPROM and the KPU lookup SRAMs.
// The master side is the sequencer: it owns addresses, data and strobes and reads EEPROM_DATA.
interface eeprom_boot_sequencer_if;
    logic [17:0] EEPROM_ADDR;
    logic [7:0]  EEPROM_DATA;
    logic        EEPROM_N_OE;
    logic [16:0] ADDR;
    logic [7:0]  DATA;
    logic [1:0]  CONTROL_LANE;
    logic        CONTROL_N_WE;
    logic        MLU_SLICE_N_WE;
    logic        MLU_LOOKAHEAD_N_WE;
    logic        N_BOOTED;

    // No valid/ready handshake on this bus: the EEPROM is read with a fixed access time
    // (EEPROM_N_OE low for EEPROM_LATENCY cycles) and each SRAM byte is written by a
    // one-cycle active-low strobe followed by one cycle of address/data hold.
    modport master (
        output EEPROM_ADDR, EEPROM_N_OE, ADDR, DATA, CONTROL_LANE,
        output CONTROL_N_WE, MLU_SLICE_N_WE, MLU_LOOKAHEAD_N_WE, N_BOOTED,
        input  EEPROM_DATA
    );

    modport slave (
        input  EEPROM_ADDR, EEPROM_N_OE, ADDR, DATA, CONTROL_LANE,
        input  CONTROL_N_WE, MLU_SLICE_N_WE, MLU_LOOKAHEAD_N_WE, N_BOOTED,
        output EEPROM_DATA
    );
endinterface

// File: rtl/eeprom_boot_sequencer.sv
// Power-on loader: copies the EEPROM boot image byte by byte into microcode, MLU slice and
// MLU lookahead SRAMs, holding N_BOOTED high until the last byte has been written.
module eeprom_boot_sequencer #(
    parameter int CTRL_DEPTH      = 12,
    parameter int SLICE_DEPTH     = 12,
    parameter int LOOKAHEAD_DEPTH = 17,
    parameter int EEPROM_LATENCY  = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    eeprom_boot_sequencer_if.master  bus,
    output logic [2:0]               state_dbg
);
    localparam int unsigned C_INT = 4 << CTRL_DEPTH;
    localparam int unsigned S_INT = 1 << SLICE_DEPTH;
    localparam int unsigned L_INT = 1 << LOOKAHEAD_DEPTH;
    localparam int unsigned T_INT = C_INT + S_INT + L_INT;
    localparam logic [17:0] C_B    = 18'(C_INT);
    localparam logic [17:0] CS_B   = 18'(C_INT + S_INT);
    localparam logic [17:0] T_LAST = 18'(T_INT - 1);
    localparam int LAT_W = (EEPROM_LATENCY > 1) ? $clog2(EEPROM_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(EEPROM_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [17:0]      b, b_d;
    logic [LAT_W-1:0] lat_cnt, lat_d;
    logic [17:0]      eeprom_addr, eeprom_addr_d;
    logic             n_oe, n_oe_d;
    logic [16:0]      addr, addr_d;
    logic [7:0]       data, data_d;
    logic [1:0]       lane, lane_d;
    logic             ctrl_n_we, ctrl_n_we_d;
    logic             slice_n_we, slice_n_we_d;
    logic             look_n_we, look_n_we_d;
    logic             n_booted, n_booted_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_START;
            b           <= '0;
            lat_cnt     <= '0;
            eeprom_addr <= '0;
            n_oe        <= 1'b1;
            addr        <= '0;
            data        <= '0;
            lane        <= '0;
            ctrl_n_we   <= 1'b1;
            slice_n_we  <= 1'b1;
            look_n_we   <= 1'b1;
            n_booted    <= 1'b1;
        end else begin
            state       <= state_d;
            b           <= b_d;
            lat_cnt     <= lat_d;
            eeprom_addr <= eeprom_addr_d;
            n_oe        <= n_oe_d;
            addr        <= addr_d;
            data        <= data_d;
            lane        <= lane_d;
            ctrl_n_we   <= ctrl_n_we_d;
            slice_n_we  <= slice_n_we_d;
            look_n_we   <= look_n_we_d;
            n_booted    <= n_booted_d;
        end
    end

    // Outputs are decoded from the next state and registered, so every pin is a flop output.
    always_comb begin
        state_d       = state;
        b_d           = b;
        lat_d         = lat_cnt;
        eeprom_addr_d = eeprom_addr;
        n_oe_d        = 1'b1;
        addr_d        = addr;
        data_d        = data;
        lane_d        = lane;
        ctrl_n_we_d   = 1'b1;
        slice_n_we_d  = 1'b1;
        look_n_we_d   = 1'b1;

        case (state)
            ST_START: begin
                state_d = ST_READ;
                lat_d   = '0;
            end
            ST_READ: begin
                if (lat_cnt == LAT_LAST) begin
                    state_d = ST_WRITE;
                    data_d  = bus.EEPROM_DATA;
                end else begin
                    lat_d = lat_cnt + 1'b1;
                end
            end
            ST_WRITE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (b == T_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                    b_d     = b + 18'd1;
                    lat_d   = '0;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_START;
        endcase

        if (state_d == ST_READ) begin
            eeprom_addr_d = b_d;
            n_oe_d        = 1'b0;
        end

        // Region select: ADDR restarts at zero at each region boundary.
        if (state_d == ST_WRITE) begin
            if (b_d < C_B) begin
                addr_d      = 17'(b_d >> 2);
                lane_d      = b_d[1:0];
                ctrl_n_we_d = 1'b0;
            end else if (b_d < CS_B) begin
                addr_d       = 17'(b_d - C_B);
                slice_n_we_d = 1'b0;
            end else begin
                addr_d      = 17'(b_d - CS_B);
                look_n_we_d = 1'b0;
            end
        end

        n_booted_d = (state_d != ST_DONE);
    end

    assign bus.EEPROM_ADDR        = eeprom_addr;
    assign bus.EEPROM_N_OE        = n_oe;
    assign bus.ADDR               = addr;
    assign bus.DATA               = data;
    assign bus.CONTROL_LANE       = lane;
    assign bus.CONTROL_N_WE       = ctrl_n_we;
    assign bus.MLU_SLICE_N_WE     = slice_n_we;
    assign bus.MLU_LOOKAHEAD_N_WE = look_n_we;
    assign bus.N_BOOTED           = n_booted;
    assign state_dbg              = state;
endmodule

// File: tb/tb_eeprom_boot_sequencer.sv
// Bench for eeprom_boot_sequencer: small image (C=16, S=4, L=8) with latency-2 and latency-1 instances,
// an EEPROM model returning addr^5A, SRAM store models and a write scoreboard.
module tb_eeprom_boot_sequencer;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;
    localparam int T     = 28;

    typedef struct {
        int          k;
        logic [1:0]  store;
        logic [16:0] addr;
        logic [1:0]  lane;
        logic [7:0]  data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic [2:0] dbg_a, dbg_b;
    int total = 0;
    int bad = 0;
    int cyc_a = 0, cyc_b = 0;
    logic rst_q_a = 1'b1, rst_q_b = 1'b1;
    int oe_cnt_a = 0, oe_cnt_b = 0;
    vec_t vecs[T];
    logic [44:0] exp_qa[$];
    logic [44:0] exp_qb[$];
    logic [31:0] ctrl_mem[4];
    logic [7:0]  slice_mem[4];
    logic [7:0]  look_mem[8];

    eeprom_boot_sequencer_if a_if();
    eeprom_boot_sequencer_if b_if();

    eeprom_boot_sequencer #(.CTRL_DEPTH(2), .SLICE_DEPTH(2), .LOOKAHEAD_DEPTH(3), .EEPROM_LATENCY(LAT_A))
        dut_a (.CLK(clk), .RST(rst_a), .bus(a_if.master), .state_dbg(dbg_a));
    eeprom_boot_sequencer #(.CTRL_DEPTH(2), .SLICE_DEPTH(2), .LOOKAHEAD_DEPTH(3), .EEPROM_LATENCY(LAT_B))
        dut_b (.CLK(clk), .RST(rst_b), .bus(b_if.master), .state_dbg(dbg_b));

    // Clock and cycle counters: cycle 0 is the first cycle after a reset edge.
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc_a   <= rst_a ? 0 : cyc_a + 1;
        cyc_b   <= rst_b ? 0 : cyc_b + 1;
        rst_q_a <= rst_a;
        rst_q_b <= rst_b;
        oe_cnt_a <= (a_if.EEPROM_N_OE || rst_a) ? 0 : oe_cnt_a + 1;
        oe_cnt_b <= (b_if.EEPROM_N_OE || rst_b) ? 0 : oe_cnt_b + 1;
    end

    // EEPROM models: garbage until the access time has elapsed with N_OE low.
    assign a_if.EEPROM_DATA = (!a_if.EEPROM_N_OE && oe_cnt_a + 1 >= LAT_A) ? (a_if.EEPROM_ADDR[7:0] ^ 8'h5A) : 8'hC3;
    assign b_if.EEPROM_DATA = (!b_if.EEPROM_N_OE && oe_cnt_b + 1 >= LAT_B) ? (b_if.EEPROM_ADDR[7:0] ^ 8'h5A) : 8'hC3;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [44:0] exp_word(input vec_t v, input int lat);
        logic [15:0] cyc;
        cyc = 16'(lat + 1 + (lat + 2) * v.k);
        return {cyc, v.store, v.addr, v.lane, v.data};
    endfunction

    // Monitor A: scoreboard, store model and continuous invariants.
    logic        wr_prev_a = 1'b0;
    logic        nb_prev_a = 1'b1;
    logic [16:0] addr_prev_a;
    logic [7:0]  data_prev_a;
    always @(negedge clk) begin
        logic [2:0]  we;
        logic [1:0]  st;
        logic [44:0] obs;
        we = {~a_if.MLU_LOOKAHEAD_N_WE, ~a_if.MLU_SLICE_N_WE, ~a_if.CONTROL_N_WE};
        check("a_one_strobe", 64'($countones(we) <= 1), 64'd1);
        if (wr_prev_a && !rst_q_a)
            check("a_hold_stable", {a_if.ADDR, a_if.DATA}, {addr_prev_a, data_prev_a});
        if (we != 3'b000) begin
            check("a_we_with_oe", 64'(a_if.EEPROM_N_OE), 64'd1);
            st = we[0] ? 2'd0 : (we[1] ? 2'd1 : 2'd2);
            obs = {16'(cyc_a), st, a_if.ADDR, (st == 2'd0) ? a_if.CONTROL_LANE : 2'd0, a_if.DATA};
            if (exp_qa.size() == 0) check("a_unexpected_write", 64'(obs), 64'd0);
            else check("a_write", 64'(obs), 64'(exp_qa.pop_front()));
            case (st)
                2'd0: ctrl_mem[a_if.ADDR[1:0]][int'(a_if.CONTROL_LANE) * 8 +: 8] = a_if.DATA;
                2'd1: slice_mem[a_if.ADDR[1:0]] = a_if.DATA;
                default: look_mem[a_if.ADDR[2:0]] = a_if.DATA;
            endcase
        end
        wr_prev_a   = (we != 3'b000);
        addr_prev_a = a_if.ADDR;
        data_prev_a = a_if.DATA;
        if (nb_prev_a && !a_if.N_BOOTED)
            check("a_nbooted_fall_cycle", 64'(cyc_a), 64'(1 + (LAT_A + 2) * T));
        if (!nb_prev_a && a_if.N_BOOTED && !rst_q_a)
            check("a_nbooted_rise_no_rst", 64'd1, 64'd0);
        nb_prev_a = a_if.N_BOOTED;
    end

    // Monitor B: latency-1 instance.
    logic nb_prev_b = 1'b1;
    always @(negedge clk) begin
        logic [2:0]  we;
        logic [1:0]  st;
        logic [44:0] obs;
        we = {~b_if.MLU_LOOKAHEAD_N_WE, ~b_if.MLU_SLICE_N_WE, ~b_if.CONTROL_N_WE};
        if (we != 3'b000) begin
            check("b_one_strobe", 64'($countones(we)), 64'd1);
            check("b_we_with_oe", 64'(b_if.EEPROM_N_OE), 64'd1);
            st = we[0] ? 2'd0 : (we[1] ? 2'd1 : 2'd2);
            obs = {16'(cyc_b), st, b_if.ADDR, (st == 2'd0) ? b_if.CONTROL_LANE : 2'd0, b_if.DATA};
            if (exp_qb.size() == 0) check("b_unexpected_write", 64'(obs), 64'd0);
            else check("b_write", 64'(obs), 64'(exp_qb.pop_front()));
        end
        if (nb_prev_b && !b_if.N_BOOTED)
            check("b_nbooted_fall_cycle", 64'(cyc_b), 64'(1 + (LAT_B + 2) * T));
        nb_prev_b = b_if.N_BOOTED;
    end

    // Called at a negedge: one reset edge, then reset values checked and the scoreboard refilled.
    task automatic do_reset_a();
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        check("a_rst_eeprom_addr", 64'(a_if.EEPROM_ADDR), 64'd0);
        check("a_rst_addr", 64'(a_if.ADDR), 64'd0);
        check("a_rst_data", 64'(a_if.DATA), 64'd0);
        check("a_rst_lane", 64'(a_if.CONTROL_LANE), 64'd0);
        check("a_rst_strobes_oe_nb",
              {a_if.CONTROL_N_WE, a_if.MLU_SLICE_N_WE, a_if.MLU_LOOKAHEAD_N_WE, a_if.EEPROM_N_OE, a_if.N_BOOTED},
              64'b11111);
        exp_qa.delete();
        for (int k = 0; k < T; k++) exp_qa.push_back(exp_word(vecs[k], LAT_A));
        for (int i = 0; i < 4; i++) begin ctrl_mem[i] = '0; slice_mem[i] = '0; end
        for (int i = 0; i < 8; i++) look_mem[i] = '0;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic reset_at_a(input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cyc_a == n) break;
        end
        check("a_reach_cycle", 64'(cyc_a), 64'(n));
    endtask

    task automatic wait_done_a();
        for (int i = 0; i < 2000; i++) begin
            if (!a_if.N_BOOTED) break;
            @(negedge clk);
        end
        check("a_boot_done", 64'(a_if.N_BOOTED), 64'd0);
        check("a_queue_drained", 64'(exp_qa.size()), 64'd0);
    endtask

    task automatic check_stores();
        logic [7:0] got;
        for (int k = 0; k < T; k++) begin
            case (vecs[k].store)
                2'd0: got = ctrl_mem[vecs[k].addr[1:0]][int'(vecs[k].lane) * 8 +: 8];
                2'd1: got = slice_mem[vecs[k].addr[1:0]];
                default: got = look_mem[vecs[k].addr[2:0]];
            endcase
            check($sformatf("store_byte_%0d", k), 64'(got), 64'(vecs[k].data));
        end
    endtask

    initial begin
        // Expected image mapping for the small bench configuration.
        for (int k = 0; k < T; k++) begin
            vecs[k].k    = k;
            vecs[k].data = 8'(k) ^ 8'h5A;
            if (k < 16) begin
                vecs[k].store = 2'd0; vecs[k].addr = 17'(k / 4); vecs[k].lane = 2'(k % 4);
            end else if (k < 20) begin
                vecs[k].store = 2'd1; vecs[k].addr = 17'(k - 16); vecs[k].lane = 2'd0;
            end else begin
                vecs[k].store = 2'd2; vecs[k].addr = 17'(k - 20); vecs[k].lane = 2'd0;
            end
        end

        // Full boot at latency 2.
        @(negedge clk);
        do_reset_a();
        wait_done_a();
        check_stores();

        // Post-boot quiescence.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("a_quiet",
                  {a_if.CONTROL_N_WE, a_if.MLU_SLICE_N_WE, a_if.MLU_LOOKAHEAD_N_WE, a_if.EEPROM_N_OE, a_if.N_BOOTED},
                  64'b11110);
        end

        // Reset from DONE, then reset mid-boot at cycle 50.
        @(negedge clk);
        do_reset_a();
        reset_at_a(50);
        do_reset_a();
        wait_done_a();
        check_stores();

        // Reset during the WRITE of byte 16, the first slice byte.
        @(negedge clk);
        do_reset_a();
        reset_at_a(LAT_A + 1 + (LAT_A + 2) * 16);
        check("a_slice_we_at_byte16", 64'(a_if.MLU_SLICE_N_WE), 64'd0);
        do_reset_a();
        check("a_restart_eeprom_addr", 64'(a_if.EEPROM_ADDR), 64'd0);
        wait_done_a();
        check_stores();

        // Latency-1 instance.
        @(negedge clk);
        rst_b = 1'b1;
        exp_qb.delete();
        for (int k = 0; k < T; k++) exp_qb.push_back(exp_word(vecs[k], LAT_B));
        @(negedge clk);
        rst_b = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!b_if.N_BOOTED) break;
            @(negedge clk);
        end
        check("b_boot_done", 64'(b_if.N_BOOTED), 64'd0);
        check("b_queue_drained", 64'(exp_qb.size()), 64'd0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
